// File: rtl/cache_ctrl_pkg.sv
// Shared field widths and FSM state encoding for the cache sequencing controller.
package cache_ctrl_pkg;

   localparam int BYTE_BITS = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WB_RD,
      S_WB_WR,
      S_FILL,
      S_REPLAY
   } state_t;

endpackage

// File: rtl/cache_ctrl.sv
// Sequences CPU loads/stores through a 2-way write-back cache, handling
// dirty-victim write-back, 4-word element refill and replay of the access.
//
// state    | meaning
// S_IDLE   | accept a CPU request and present it to the cache
// S_LOOKUP | registered hit result visible; release stall or start miss
// S_WB_RD  | cache registers the next victim word
// S_WB_WR  | victim word written to memory, waiting for ack
// S_FILL   | element words read from memory and stored into the cache
// S_REPLAY | original access re-issued from the latched request
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_BITS           = 32,
   parameter int TAG_BITS            = 23,
   parameter int SET_INDEX_WIDTH     = 5,
   parameter int ELEMENT_WORDS_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_r,
   input  logic                 en_w,
   input  logic [2:0]           u_b_h_w,
   input  logic [ADDR_BITS-1:0] addr_rw,
   input  logic [31:0]          data_w,
   output logic [31:0]          data_r,
   output logic                 stall,
   output logic [ADDR_BITS-1:0] cache_addr,
   output logic                 cache_load,
   output logic                 cache_edit,
   output logic                 cache_store,
   output logic [2:0]           cache_u_b_h_w,
   output logic [31:0]          cache_din,
   input  logic                 cache_hit,
   input  logic [31:0]          cache_dout,
   input  logic                 cache_valid,
   input  logic                 cache_dirty,
   input  logic [TAG_BITS-1:0]  cache_tag,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_dout,
   input  logic [31:0]          mem_din,
   input  logic                 mem_ack
);

   localparam int INDEX_LSB = ELEMENT_WORDS_WIDTH + BYTE_BITS;
   localparam int INDEX_MSB = INDEX_LSB + SET_INDEX_WIDTH - 1;

   state_t                         state;
   logic [ELEMENT_WORDS_WIDTH-1:0] word_cnt;
   logic [ADDR_BITS-1:0]           req_addr;
   logic [31:0]                    req_data;
   logic [2:0]                     req_ubhw;
   logic                           req_we;
   logic [TAG_BITS-1:0]            vic_tag;

   logic [TAG_BITS-1:0]            req_tag;
   logic [SET_INDEX_WIDTH-1:0]     req_index;
   logic [ADDR_BITS-1:0]           elem_addr;
   logic [ADDR_BITS-1:0]           vic_addr;

   assign req_tag   = req_addr[ADDR_BITS-1 -: TAG_BITS];
   assign req_index = req_addr[INDEX_MSB:INDEX_LSB];
   assign elem_addr = {req_tag, req_index, word_cnt, {BYTE_BITS{1'b0}}};
   assign vic_addr  = {vic_tag, req_index, word_cnt, {BYTE_BITS{1'b0}}};

   assign stall  = (en_r | en_w) & ~((state == S_LOOKUP) & cache_hit);
   assign data_r = cache_dout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         word_cnt <= '0;
         req_addr <= '0;
         req_data <= '0;
         req_ubhw <= '0;
         req_we   <= 1'b0;
         vic_tag  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en_r | en_w) begin
                  req_addr <= addr_rw;
                  req_data <= data_w;
                  req_ubhw <= u_b_h_w;
                  req_we   <= en_w;
                  state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (cache_hit) begin
                  state <= S_IDLE;
               end else begin
                  vic_tag  <= cache_tag;
                  word_cnt <= '0;
                  state    <= (cache_valid & cache_dirty) ? S_WB_RD : S_FILL;
               end
            end
            S_WB_RD: state <= S_WB_WR;
            S_WB_WR: begin
               if (mem_ack) begin
                  word_cnt <= word_cnt + 1'b1;
                  state    <= (word_cnt == '1) ? S_FILL : S_WB_RD;
               end
            end
            S_FILL: begin
               if (mem_ack) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == '1) state <= S_REPLAY;
               end
            end
            S_REPLAY: state <= S_LOOKUP;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      cache_addr    = req_addr;
      cache_load    = 1'b0;
      cache_edit    = 1'b0;
      cache_store   = 1'b0;
      cache_u_b_h_w = req_ubhw;
      cache_din     = req_data;
      mem_cs        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = elem_addr;
      mem_dout      = cache_dout;
      case (state)
         S_IDLE: begin
            cache_addr    = addr_rw;
            cache_u_b_h_w = u_b_h_w;
            cache_din     = data_w;
            cache_load    = en_r & ~en_w;
            cache_edit    = en_w;
         end
         S_WB_RD: cache_addr = elem_addr;
         S_WB_WR: begin
            cache_addr = elem_addr;
            mem_cs     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = vic_addr;
         end
         S_FILL: begin
            cache_addr = elem_addr;
            mem_cs     = 1'b1;
            if (mem_ack) begin
               cache_store = 1'b1;
               cache_din   = mem_din;
            end
         end
         S_REPLAY: begin
            cache_load = ~req_we;
            cache_edit = req_we;
         end
         default: ;
      endcase
      // Reset is synchronous, so the cycle it is applied must already be quiet.
      if (!rst) begin
         cache_load  = 1'b0;
         cache_edit  = 1'b0;
         cache_store = 1'b0;
         mem_cs      = 1'b0;
         mem_we      = 1'b0;
      end
   end

endmodule
